// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data requests win in IDLE; ihit/dhit are combinational with ram_ready.
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [WORD_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemload,
  output logic              dhit,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              halted,
  output logic              err,
  output logic [15:0]       icount,
  output logic [15:0]       dcount
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, INSTR, HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [7:0]        wait_q, wait_d;
  logic              err_q, err_d;
  logic [15:0]       icnt_q, icnt_d;
  logic [15:0]       dcnt_q, dcnt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dmemREN | dmemWEN) state_d = DATA;
        else if (halt)         state_d = HALTED;
        else if (imemREN)      state_d = INSTR;
      end
      DATA:    if (ram_ready) state_d = IDLE;
      INSTR:   if (ram_ready) state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ihit   = 1'b0;
    dhit   = 1'b0;
    halted = 1'b0;
    case (state_q)
      DATA: begin
        ramWEN = wr_q;
        ramREN = ~wr_q;
        dhit   = ram_ready;
      end
      INSTR: begin
        ramREN = 1'b1;
        ihit   = ram_ready;
      end
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  // A simultaneous read+write is latched as a write; the wait counter
  // saturates at TIMEOUT so err is raised exactly once per stall.
  always_comb begin
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (dmemREN | dmemWEN) begin
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
          wait_d  = '0;
          if (dmemREN & dmemWEN) err_d = 1'b1;
        end else if (!halt && imemREN) begin
          addr_d = imemaddr;
          wait_d = '0;
        end
      end
      DATA, INSTR: begin
        if (ram_ready) begin
          if (state_q == DATA) dcnt_d = dcnt_q + 16'd1;
          else                 icnt_d = icnt_q + 16'd1;
        end else begin
          if (wait_q != TMO)         wait_d = wait_q + 8'd1;
          if (wait_q == TMO - 8'd1)  err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;
  assign icount   = icnt_q;
  assign dcount   = dcnt_q;
  assign imemload = ramload;
  assign dmemload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; each record is one clock cycle.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        imemREN, dmemREN, dmemWEN, halt, ram_ready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, halted, err;
  logic [15:0] icount, dcount;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_arbiter #(.WORD_W(32), .ADDR_W(32), .TIMEOUT(255)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .halt(halt), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
    .halted(halted), .err(err), .icount(icount), .dcount(dcount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  in_bits;   // {nrst, iren, dren, dwen, halt, rdy}
    logic [31:0] ia, da, ds;
    logic [5:0]  out_bits;  // {ren, wen, ihit, dhit, halted, err}
    logic [31:0] ra, rs;
    logic [15:0] ic, dc;
  } vec_t;

  function automatic vec_t v(input logic [5:0] ib, input logic [31:0] ia, da, ds,
                             input logic [5:0] ob, input logic [31:0] ra, rs,
                             input logic [15:0] ic, dc);
    vec_t x;
    x.in_bits = ib; x.ia = ia; x.da = da; x.ds = ds;
    x.out_bits = ob; x.ra = ra; x.rs = rs; x.ic = ic; x.dc = dc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    {nRST, imemREN, dmemREN, dmemWEN, halt, ram_ready} = x.in_bits;
    imemaddr  = x.ia;
    dmemaddr  = x.da;
    dmemstore = x.ds;
  endtask

  // Drive on the falling edge, sample 1 time unit later, well away from posedge.
  task automatic run(input vec_t x, input string tag);
    @(negedge CLK);
    drive(x);
    #1;
    chk({tag, ".ramREN"},   {31'd0, ramREN},  {31'd0, x.out_bits[5]});
    chk({tag, ".ramWEN"},   {31'd0, ramWEN},  {31'd0, x.out_bits[4]});
    chk({tag, ".ihit"},     {31'd0, ihit},    {31'd0, x.out_bits[3]});
    chk({tag, ".dhit"},     {31'd0, dhit},    {31'd0, x.out_bits[2]});
    chk({tag, ".halted"},   {31'd0, halted},  {31'd0, x.out_bits[1]});
    chk({tag, ".err"},      {31'd0, err},     {31'd0, x.out_bits[0]});
    chk({tag, ".ramaddr"},  ramaddr,  x.ra);
    chk({tag, ".ramstore"}, ramstore, x.rs);
    chk({tag, ".icount"},   {16'd0, icount}, {16'd0, x.ic});
    chk({tag, ".dcount"},   {16'd0, dcount}, {16'd0, x.dc});
    chk({tag, ".imemload"}, imemload, ramload);
    chk({tag, ".dmemload"}, dmemload, ramload);
  endtask

  vec_t tbl[19];

  initial begin
    ramload = 32'hA5A5_0001;
    drive(v(6'b000000, 0, 0, 0, 6'b0, 0, 0, 0, 0));

    // reset with requests active, then fetch 0x40 dropped mid-transaction
    tbl[0]  = v(6'b011101, 32'h40, 32'h100, 32'h0,        6'b000000, 32'h0,   32'h0,        0, 0);
    tbl[1]  = v(6'b110000, 32'h40, 32'h0,   32'h0,        6'b000000, 32'h0,   32'h0,        0, 0);
    tbl[2]  = v(6'b110000, 32'h40, 32'h0,   32'h0,        6'b100000, 32'h40,  32'h0,        0, 0);
    tbl[3]  = v(6'b100001, 32'h40, 32'h0,   32'h0,        6'b101000, 32'h40,  32'h0,        0, 0);
    // priority: data beats fetch, ready two cycles late
    tbl[4]  = v(6'b111000, 32'h80, 32'h100, 32'h11,       6'b000000, 32'h40,  32'h0,        1, 0);
    tbl[5]  = v(6'b111000, 32'h80, 32'h100, 32'h11,       6'b100000, 32'h100, 32'h11,       1, 0);
    tbl[6]  = v(6'b111000, 32'h80, 32'h100, 32'h11,       6'b100000, 32'h100, 32'h11,       1, 0);
    tbl[7]  = v(6'b111001, 32'h80, 32'h100, 32'h11,       6'b100100, 32'h100, 32'h11,       1, 0);
    tbl[8]  = v(6'b110000, 32'h80, 32'h0,   32'h0,        6'b000000, 32'h100, 32'h11,       1, 1);
    tbl[9]  = v(6'b110001, 32'h80, 32'h0,   32'h0,        6'b101000, 32'h80,  32'h11,       1, 1);
    // store with immediate ready; ready in IDLE must not produce a hit
    tbl[10] = v(6'b100101, 32'h0,  32'h200, 32'hDEADBEEF, 6'b000000, 32'h80,  32'h11,       2, 1);
    tbl[11] = v(6'b100101, 32'h0,  32'h200, 32'hDEADBEEF, 6'b010100, 32'h200, 32'hDEADBEEF, 2, 1);
    tbl[12] = v(6'b100000, 32'h0,  32'h0,   32'h0,        6'b000000, 32'h200, 32'hDEADBEEF, 2, 2);
    // halt during a fetch wait
    tbl[13] = v(6'b110000, 32'h300, 32'h0,  32'h0,        6'b000000, 32'h200, 32'hDEADBEEF, 2, 2);
    tbl[14] = v(6'b110010, 32'h300, 32'h0,  32'h0,        6'b100000, 32'h300, 32'hDEADBEEF, 2, 2);
    tbl[15] = v(6'b110011, 32'h300, 32'h0,  32'h0,        6'b101000, 32'h300, 32'hDEADBEEF, 2, 2);
    tbl[16] = v(6'b110010, 32'h400, 32'h0,  32'h0,        6'b000000, 32'h300, 32'hDEADBEEF, 3, 2);
    tbl[17] = v(6'b111001, 32'h400, 32'h500, 32'h0,       6'b000010, 32'h300, 32'hDEADBEEF, 3, 2);
    tbl[18] = v(6'b111001, 32'h400, 32'h500, 32'h0,       6'b000010, 32'h300, 32'hDEADBEEF, 3, 2);

    for (int i = 0; i < 19; i++) run(tbl[i], $sformatf("row%0d", i));

    // conflicting read+write: treated as write, err sets
    run(v(6'b000000, 0, 0,       0,     6'b000000, 0,       0,     0, 0), "cf_rst");
    run(v(6'b101100, 0, 32'h500, 32'h55, 6'b000000, 0,       0,     0, 0), "cf_idle");
    run(v(6'b101100, 0, 32'h500, 32'h55, 6'b010001, 32'h500, 32'h55, 0, 0), "cf_wait");
    run(v(6'b101101, 0, 32'h500, 32'h55, 6'b010101, 32'h500, 32'h55, 0, 0), "cf_hit");
    run(v(6'b100000, 0, 0,       0,     6'b000001, 32'h500, 32'h55, 0, 1), "cf_after");

    // timeout: 254 stalled cycles leave err clear, the 255th sets it
    run(v(6'b000000, 0, 0,       0, 6'b000000, 0, 0, 0, 0), "to_rst");
    run(v(6'b101000, 0, 32'h600, 0, 6'b000000, 0, 0, 0, 0), "to_idle");
    for (int i = 0; i < 254; i++) begin
      @(negedge CLK);
      drive(v(6'b101000, 0, 32'h600, 0, 6'b0, 0, 0, 0, 0));
    end
    run(v(6'b101000, 0, 32'h600, 0, 6'b100000, 32'h600, 0, 0, 0), "to_255");
    run(v(6'b101000, 0, 32'h600, 0, 6'b100001, 32'h600, 0, 0, 0), "to_set");
    run(v(6'b101001, 0, 32'h600, 0, 6'b100101, 32'h600, 0, 0, 0), "to_hit");
    run(v(6'b100000, 0, 0,       0, 6'b000001, 32'h600, 0, 0, 1), "to_sticky");

    // icount wrap: preload 0xFFFF in IDLE, then complete one fetch
    run(v(6'b000000, 0, 0, 0, 6'b000000, 0, 0, 0, 0), "wr_rst");
    @(negedge CLK);
    drive(v(6'b100000, 0, 0, 0, 6'b0, 0, 0, 0, 0));
    force dut.icnt_q = 16'hFFFF;
    #1;
    release dut.icnt_q;
    run(v(6'b110000, 32'h40, 0, 0, 6'b000000, 0,      0, 16'hFFFF, 0), "wr_idle");
    run(v(6'b110001, 32'h40, 0, 0, 6'b101000, 32'h40, 0, 16'hFFFF, 0), "wr_hit");
    run(v(6'b100000, 32'h0,  0, 0, 6'b000000, 32'h40, 0, 16'h0000, 0), "wr_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch and data-access requests and a shared RAM. It is the responder that generates `ihit` and `dhit`, the strobes the pipeline registers use to advance or flush. Data requests take priority over fetches. The block tracks completed transactions and flags RAM stalls that exceed a timeout. It sits between the datapath and the RAM model or controller.

## Interface
- `WORD_W`, 32, data width
- `ADDR_W`, 32, address width
- `TIMEOUT`, 255, max cycles in a RAM-wait state before `err` sets (8-bit counter)
- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  reset; asynchronous, active-low
- `imemREN`  in  1  fetch request
- `imemaddr`  in  ADDR_W  fetch address
- `imemload`  out  WORD_W  fetched word; equals `ramload` pass-through
- `ihit`  out  1  fetch complete, one-cycle strobe
- `dmemREN`  in  1  load request
- `dmemWEN`  in  1  store request
- `dmemaddr`  in  ADDR_W  data address
- `dmemstore`  in  WORD_W  store data
- `dmemload`  out  WORD_W  load word; equals `ramload` pass-through
- `dhit`  out  1  data access complete, one-cycle strobe
- `halt`  in  1  CPU halt request
- `ramREN`  out  1  RAM read enable
- `ramWEN`  out  1  RAM write enable
- `ramaddr`  out  ADDR_W  RAM address (registered)
- `ramstore`  out  WORD_W  RAM write data (registered)
- `ramload`  in  WORD_W  RAM read data
- `ram_ready`  in  1  RAM completes the current access this cycle
- `halted`  out  1  arbiter idle permanently after halt
- `err`  out  1  sticky timeout or conflicting-request flag
- `icount`  out  16  completed fetches, wraps at 0xFFFF→0
- `dcount`  out  16  completed data accesses, wraps

## Operation
- States: IDLE, DATA, INSTR, HALTED. Reset → IDLE.
- IDLE:
  - If `dmemREN | dmemWEN`: latch `dmemaddr`→`ramaddr`, `dmemstore`→`ramstore`, and the direction bit; go to DATA.
  - Else if `halt`: go to HALTED.
  - Else if `imemREN`: latch `imemaddr`→`ramaddr`; go to INSTR.
  - Else stay in IDLE.
- `dmemREN & dmemWEN` together: treated as a write, and `err` sets.
- DATA:
  - `ramWEN` = latched write, `ramREN` = latched read.
  - On `ram_ready`: `dhit` = 1 combinationally, `dcount`++, next state IDLE.
- INSTR:
  - `ramREN` = 1.
  - On `ram_ready`: `ihit` = 1, `icount`++, next state IDLE.
  - Dropping `imemREN` mid-transaction does not abort it; `ihit` still pulses.
  - `halt` arriving during INSTR is honoured in the following IDLE. Pending data requests are still served first.
- HALTED:
  - `halted` = 1, all RAM enables 0, hits 0.
  - Held until reset; requests are ignored.
- Wait counter:
  - Clears on entry to DATA or INSTR and increments each cycle without `ram_ready`.
  - Reaching `TIMEOUT` sets `err`. The transaction continues waiting.
- `ihit` and `dhit` are never high together. Neither is high outside its state.
- Reset values: `ramREN` = `ramWEN` = 0, `ramaddr` = `ramstore` = 0, `ihit` = `dhit` = 0, `halted` = 0, `err` = 0, `icount` = `dcount` = 0, wait counter 0.
- Reset mid-transaction: immediate return to IDLE with enables 0. No hit is issued.

## Timing
- Request sampled in IDLE at edge N. RAM enable is asserted from cycle N+1.
- Hit is issued in the first cycle of DATA/INSTR with `ram_ready` = 1. Minimum latency from request to hit is 1 cycle after IDLE.
- The hit is combinational with `ram_ready`, so the pipeline register updates on the same edge the FSM returns to IDLE. The request seen in the next IDLE cycle is therefore the new one, and no duplicate access occurs.
- There is one IDLE bubble between consecutive transactions. Back-to-back throughput is 1 access per (2 + wait) cycles.
- Priority is evaluated only in IDLE; an in-flight fetch is never pre-empted.
- Counters and `err` update on the clock edge ending the hit or timeout cycle.

## Test plan
- Reset: hold `nRST` = 0 with requests active. All outputs are 0 and state is IDLE. Release reset with `imemREN` = 1 and addr 0x40; `ramREN` rises next cycle with `ramaddr` = 0x40.
- Priority: assert `imemREN` and `dmemREN` (addr 0x100) in the same IDLE cycle, with `ram_ready` 2 cycles later. `dhit` = 1 and `dcount` = 1 first; after the bubble, the fetch proceeds and `ihit` follows.
- Store: `dmemWEN` with addr 0x200 and data 0xDEADBEEF, `ram_ready` immediate. `ramWEN` = 1 and `ramstore` = 0xDEADBEEF for exactly one cycle, with `dhit` in that cycle.
- Halt: `halt` = 1 during an INSTR wait. The fetch completes with `ihit`, the next IDLE goes to HALTED, `halted` = 1, and further `imemREN` produces no `ramREN`.
- Timeout/conflict: hold `ram_ready` = 0 for 255 cycles in DATA; `err` sets and stays 1 after `ram_ready` arrives. Separately, `dmemREN` and `dmemWEN` both at 1 causes a write and sets `err`.
- Wrap: preload 0xFFFF fetches (or force the counter) and complete one more fetch; `icount` = 0.
